flash_write: RTL and testbench



---
 rtl/flash_write.sv | 190 +++++++++++++++++++
 tb/tb_flash_write.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_write.sv
// SPI NOR flash programmer (mode 0): erases 4 KB sectors on first touch, programs
// 256-byte pages from a 16-bit word stream and polls WIP after every erase/program.
module flash_write #(
    parameter int          CS_HIGH_CYC = 4,
    parameter logic [23:0] POLL_MAX    = 24'd4000000
) (
    input  logic        clock,
    input  logic        flash_rst,
    input  logic        start,
    input  logic [23:0] base_addr,
    input  logic [15:0] word_count,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        flash_clk,
    output logic        flash_cs,
    output logic        flash_datain,
    input  logic        flash_dataout
);

    localparam logic [7:0] GAP = 8'(CS_HIGH_CYC - 1);

    typedef enum logic [2:0] {IDLE, WREN_E, ERASE, POLL, WREN_P, PROG_HDR, PROG_DATA, FINISH} state_t;
    typedef enum logic [1:0] {PH_LOAD, PH_SHIFT, PH_GAP} phase_t;

    state_t      state, nxt, ret;
    phase_t      ph;
    logic [31:0] tx;
    logic [5:0]  nbits;
    logic        rd;
    logic [23:0] addr;
    logic [15:0] remaining;
    logic [23:0] poll_cnt;
    logic [7:0]  gap_cnt;
    logic [31:0] cmd;
    logic [5:0]  cmd_bits;
    logic        unused_bits;

    assign unused_bits = ^base_addr[11:0];

    // Ready depends on valid so it is high only in the cycle a word is actually taken.
    assign wr_ready = (state == PROG_DATA) && (ph == PH_LOAD) && wr_valid;

    always_comb begin
        cmd      = '0;
        cmd_bits = '0;
        case (state)
            WREN_E, WREN_P: begin cmd = {8'h06, 24'h0};  cmd_bits = 6'd8;  end
            ERASE:          begin cmd = {8'h20, addr};   cmd_bits = 6'd32; end
            POLL:           begin cmd = {8'h05, 24'h0};  cmd_bits = 6'd8;  end
            PROG_HDR:       begin cmd = {8'h02, addr};   cmd_bits = 6'd32; end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        done <= 1'b0;
        if (flash_rst) begin
            state        <= IDLE;
            nxt          <= IDLE;
            ret          <= IDLE;
            ph           <= PH_LOAD;
            tx           <= '0;
            nbits        <= '0;
            rd           <= 1'b0;
            addr         <= '0;
            remaining    <= '0;
            poll_cnt     <= '0;
            gap_cnt      <= '0;
            busy         <= 1'b0;
            error        <= 1'b0;
            flash_cs     <= 1'b1;
            flash_clk    <= 1'b0;
            flash_datain <= 1'b1;
        end else begin
            case (ph)
                PH_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= nxt;
                        ph    <= PH_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                PH_LOAD: begin
                    case (state)
                        IDLE: if (start) begin
                            if (word_count == 16'd0) begin
                                done <= 1'b1;
                            end else begin
                                addr      <= {base_addr[23:12], 12'h000};
                                remaining <= word_count;
                                busy      <= 1'b1;
                                error     <= 1'b0;
                                state     <= WREN_E;
                            end
                        end
                        PROG_DATA: if (wr_valid) begin
                            tx           <= {wr_data, 16'h0};
                            flash_datain <= wr_data[15];
                            nbits        <= 6'd16;
                            ph           <= PH_SHIFT;
                        end
                        FINISH: begin
                            flash_cs     <= 1'b1;
                            flash_datain <= 1'b1;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end
                        default: begin
                            tx           <= cmd;
                            flash_datain <= cmd[31];
                            nbits        <= cmd_bits;
                            flash_cs     <= 1'b0;
                            rd           <= 1'b0;
                            poll_cnt     <= '0;
                            ph           <= PH_SHIFT;
                        end
                    endcase
                end
                default: begin
                    // Falling SCK edge: MISO is sampled and the next MOSI bit presented together.
                    if (!flash_clk) begin
                        flash_clk <= 1'b1;
                    end else begin
                        flash_clk    <= 1'b0;
                        tx           <= {tx[30:0], 1'b0};
                        flash_datain <= tx[30];
                        nbits        <= nbits - 6'd1;
                        if (nbits == 6'd1) begin
                            case (state)
                                WREN_E: begin
                                    flash_cs <= 1'b1; ph <= PH_GAP; gap_cnt <= GAP; nxt <= ERASE;
                                end
                                WREN_P: begin
                                    flash_cs <= 1'b1; ph <= PH_GAP; gap_cnt <= GAP; nxt <= PROG_HDR;
                                end
                                ERASE: begin
                                    flash_cs <= 1'b1; ph <= PH_GAP; gap_cnt <= GAP; nxt <= POLL;
                                    ret      <= WREN_P;
                                end
                                PROG_HDR: begin
                                    state <= PROG_DATA;
                                    ph    <= PH_LOAD;
                                end
                                PROG_DATA: begin
                                    addr      <= addr + 24'd2;
                                    remaining <= remaining - 16'd1;
                                    if (remaining == 16'd1 || addr[7:0] == 8'hFE) begin
                                        flash_cs <= 1'b1; ph <= PH_GAP; gap_cnt <= GAP; nxt <= POLL;
                                        if (remaining == 16'd1)          ret <= FINISH;
                                        else if (addr[11:0] == 12'hFFE)  ret <= WREN_E;
                                        else                             ret <= WREN_P;
                                    end else begin
                                        ph <= PH_LOAD;
                                    end
                                end
                                POLL: begin
                                    // flash_dataout here is bit0 (WIP) of the byte just received.
                                    if (!rd) begin
                                        rd           <= 1'b1;
                                        nbits        <= 6'd8;
                                        flash_datain <= 1'b0;
                                    end else if (!flash_dataout) begin
                                        flash_cs <= 1'b1; ph <= PH_GAP; gap_cnt <= GAP; nxt <= ret;
                                    end else if (poll_cnt == POLL_MAX - 24'd1) begin
                                        error    <= 1'b1;
                                        flash_cs <= 1'b1;
                                        state    <= FINISH;
                                        ph       <= PH_LOAD;
                                    end else begin
                                        poll_cnt     <= poll_cnt + 24'd1;
                                        nbits        <= 6'd8;
                                        flash_datain <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_write.sv
// Bench for flash_write: SPI flash model with scripted WIP, word-stream driver and
// a frame-level reference of the expected MOSI byte sequence.
module tb_flash_write;

    localparam int CSH  = 4;
    localparam int PMAX = 16;

    logic        clock = 0;
    logic        flash_rst, start, wr_valid, wr_ready, busy, done, error;
    logic        flash_clk, flash_cs, flash_datain, flash_dataout;
    logic [23:0] base_addr;
    logic [15:0] word_count, wr_data;

    flash_write #(.CS_HIGH_CYC(CSH), .POLL_MAX(24'd16)) dut (
        .clock(clock), .flash_rst(flash_rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done), .error(error), .flash_clk(flash_clk), .flash_cs(flash_cs),
        .flash_datain(flash_datain), .flash_dataout(flash_dataout)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;

    // ---------------- flash model / bus monitor ----------------
    logic [7:0]  act_q[$], fb[$], exp_q[$], sh = 0;
    logic        is_poll = 0, miso = 0, wip_stuck = 0;
    int          bitcnt = 0, wip_n = 0, n_frames = 0, n_erase = 0, n_prog = 0, bad_frames = 0;
    int          last_poll_bytes = 0, clk_edges = 0, cs_falls = 0, e_er, e_pr;
    int          hi_run = 0, min_gap = 1000, done_cnt = 0, busy_cnt = 0;

    assign flash_dataout = miso;

    always @(negedge flash_cs) begin
        bitcnt = 0; fb.delete(); is_poll = 0; miso = 0; cs_falls++;
    end

    always @(posedge flash_clk) begin
        clk_edges++;
        if (flash_cs === 1'b0) begin
            sh = {sh[6:0], flash_datain};
            bitcnt++;
            if (bitcnt % 8 == 0) begin
                fb.push_back(sh);
                if (bitcnt == 8 && sh == 8'h05) is_poll = 1;
            end
            miso = 0;
            // Status byte k after the 05 command: bit0 = WIP for the first wip_n bytes.
            if (is_poll && bitcnt > 8 && (bitcnt - 9) % 8 == 7)
                miso = wip_stuck || ((bitcnt - 9) / 8 < wip_n);
        end
    end

    always @(posedge flash_cs) begin
        if (fb.size() > 0) begin
            n_frames++;
            if (bitcnt % 8 != 0) bad_frames++;
            if (is_poll) begin
                act_q.push_back(8'h05);
                last_poll_bytes = (bitcnt - 8) / 8;
            end else begin
                foreach (fb[i]) act_q.push_back(fb[i]);
                if (fb[0] == 8'h20) n_erase++;
                if (fb[0] == 8'h02) n_prog++;
            end
        end
    end

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (flash_cs === 1'b1) hi_run++;
        else begin
            if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
        end
    end

    // ---------------- word-stream driver ----------------
    logic [15:0] wq[$], words[$];
    int          n_acc = 0, stall_at = 0, stall_left = 0, stall_hits = 0, stall_bad = 0;

    initial begin
        wr_valid = 0; wr_data = 0;
        forever begin
            @(negedge clock);
            if (stall_left > 0) begin
                // Late in the stall the current word has drained, so SCK must be parked.
                if (stall_left <= 25) begin
                    stall_hits++;
                    if (flash_clk !== 1'b0 || flash_cs !== 1'b0) stall_bad++;
                end
                wr_valid = 0;
                stall_left--;
            end else if (wq.size() > 0) begin
                wr_valid = 1; wr_data = wq[0];
            end else begin
                wr_valid = 0;
            end
            #4;
            if (wr_valid && wr_ready) begin
                void'(wq.pop_front());
                n_acc++;
                if (n_acc == stall_at) stall_left = 60;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected MOSI stream: status reads are reduced to their 05 command byte.
    task automatic build_exp(input logic [23:0] base, input logic [15:0] w[$]);
        logic [23:0] a;
        int i;
        exp_q.delete(); e_er = 0; e_pr = 0; i = 0;
        a = {base[23:12], 12'h000};
        while (i < w.size()) begin
            if (a[11:0] == 12'h000) begin
                exp_q.push_back(8'h06);
                exp_q.push_back(8'h20); exp_q.push_back(a[23:16]); exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
                exp_q.push_back(8'h05);
                e_er++;
            end
            exp_q.push_back(8'h06);
            exp_q.push_back(8'h02); exp_q.push_back(a[23:16]); exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
            e_pr++;
            do begin
                exp_q.push_back(w[i][15:8]); exp_q.push_back(w[i][7:0]);
                a = a + 24'd2; i++;
            end while (i < w.size() && a[7:0] != 8'h00);
            exp_q.push_back(8'h05);
        end
    endtask

    task automatic compare_stream(input string tag);
        int first_bad = -1;
        chk({tag, "_len"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            if (first_bad < 0 && act_q[i] !== exp_q[i]) first_bad = i;
        chk({tag, "_first_bad_byte"}, first_bad, -1);
    endtask

    task automatic clear_mon();
        act_q.delete(); n_frames = 0; n_erase = 0; n_prog = 0; bad_frames = 0;
        min_gap = 1000; done_cnt = 0; n_acc = 0; stall_hits = 0; stall_bad = 0;
    endtask

    task automatic pulse_start(input logic [23:0] base, input int cnt);
        @(negedge clock);
        base_addr = base; word_count = 16'(cnt); start = 1;
        @(negedge clock);
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clock);
            if (done === 1'b1) got = 1;
        end
        chk({tag, "_done_seen"}, got, 1);
    endtask

    task automatic run_op(input string tag, input logic [23:0] base, input int wipn, input int stall_w);
        clear_mon();
        wip_n = wipn; wip_stuck = 0; stall_at = stall_w;
        build_exp(base, words);
        wq = words;
        pulse_start(base, words.size());
        chk({tag, "_busy_up"}, busy, 1);
        wait_done(tag, words.size() * 40 + 4000);
        repeat (3) @(negedge clock);
        chk({tag, "_done_once"}, done_cnt, 1);
        compare_stream(tag);
        chk({tag, "_erases"}, n_erase, e_er);
        chk({tag, "_progs"}, n_prog, e_pr);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_busy_down"}, busy, 0);
        chk({tag, "_byte_aligned"}, bad_frames, 0);
        chk({tag, "_cs_gap_ok"}, min_gap >= CSH, 1);
        chk({tag, "_words_used"}, wq.size(), 0);
        if (stall_w > 0) begin
            chk({tag, "_stall_clean"}, stall_bad, 0);
            chk({tag, "_stall_seen"}, stall_hits >= 20, 1);
        end
        stall_at = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ce, cf, bc;
        bit hit;
        flash_rst = 1; start = 0; base_addr = 0; word_count = 0;
        repeat (3) @(negedge clock);
        chk("rst_cs", flash_cs, 1);
        chk("rst_clk", flash_clk, 0);
        chk("rst_mosi", flash_datain, 1);
        chk("rst_ready", wr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        flash_rst = 0;
        repeat (2) @(negedge clock);

        // Zero-length request
        ce = clk_edges; cf = cs_falls; bc = busy_cnt;
        pulse_start(24'h060000, 0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        @(negedge clock);
        chk("zero_done_drop", done, 0);
        chk("zero_cs", flash_cs, 1);
        chk("zero_no_sck", clk_edges - ce, 0);
        chk("zero_no_cs", cs_falls - cf, 0);
        chk("zero_no_busy", busy_cnt - bc, 0);

        // Short write, two busy status bytes per poll
        words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        run_op("short", 24'h060123, 2, 0);

        // Page split
        words.delete();
        for (int i = 0; i < 129; i++) words.push_back(16'($urandom));
        run_op("page", 24'h060000, 1, 0);
        chk("page_one_erase", n_erase, 1);
        chk("page_two_progs", n_prog, 2);

        // Stall mid-page
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(16'($urandom));
        run_op("stall", 24'h010000, 1, 5);

        // Randomized requests
        for (int r = 0; r < 2; r++) begin
            words.delete();
            for (int i = 0; i < $urandom_range(1, 60); i++) words.push_back(16'($urandom));
            run_op("rand", 24'($urandom), $urandom_range(0, 3), 0);
        end

        // Sector crossing
        words.delete();
        for (int i = 0; i < 2049; i++) words.push_back(16'($urandom));
        run_op("sector", 24'h060000, 0, 0);
        chk("sector_two_erases", n_erase, 2);
        chk("sector_17_progs", n_prog, 17);

        // Poll timeout with WIP stuck at 1
        clear_mon();
        wip_stuck = 1; wip_n = 0;
        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        exp_q = '{8'h06, 8'h20, 8'h07, 8'h00, 8'h00, 8'h05};
        pulse_start(24'h070ABC, 4);
        wait_done("tmo", 4000);
        chk("tmo_error", error, 1);
        chk("tmo_cs", flash_cs, 1);
        repeat (3) @(negedge clock);
        chk("tmo_done_once", done_cnt, 1);
        chk("tmo_status_bytes", last_poll_bytes, PMAX);
        chk("tmo_no_prog", n_prog, 0);
        chk("tmo_busy", busy, 0);
        compare_stream("tmo");
        repeat (5) @(negedge clock);
        chk("tmo_error_sticky", error, 1);
        wip_stuck = 0;
        wq.delete();

        // Reset in the middle of PROG_DATA
        clear_mon();
        wip_n = 0;
        for (int i = 0; i < 200; i++) wq.push_back(16'($urandom));
        pulse_start(24'h100000, 200);
        chk("rstop_error_cleared", error, 0);
        hit = 0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clock);
            if (n_acc >= 3) hit = 1;
        end
        chk("rstop_in_prog", hit, 1);
        flash_rst = 1;
        @(negedge clock);
        chk("rstop_cs", flash_cs, 1);
        chk("rstop_busy", busy, 0);
        chk("rstop_ready", wr_ready, 0);
        flash_rst = 0;
        wq.delete();
        repeat (3) @(negedge clock);

        // Recovery after abandoned transfer
        words = '{16'hCAFE, 16'hBEEF};
        run_op("recover", 24'hFFF000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
